// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN output packing path.
// Holds the system default widths and the frame-position FSM encoding.
// Also holds the helper that sizes the pixel counter.
package cnn_pkg;

  localparam int DEF_DATA_WIDTH   = 20;
  localparam int DEF_TDATA_WIDTH  = 32;
  localparam int DEF_FRAME_PIXELS = 57600;
  localparam int DEF_FIFO_DEPTH   = 512;

  // Counter width that still works for a degenerate one-pixel frame.
  function automatic int cnt_width(input int pixels);
    return (pixels > 1) ? $clog2(pixels) : 1;
  endfunction

  localparam int CNT_W = $clog2(DEF_FRAME_PIXELS);

  // Input-side frame tracking: IDLE means the next sample opens a frame.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } pack_state_e;

  // One buffered word at the system default width.
  // Fields are ordered MSB first: sof, last, data.
  typedef struct packed {
    logic                       sof;
    logic                       last;
    logic [DEF_TDATA_WIDTH-1:0] data;
  } fmap_entry_t;

endpackage

// File: rtl/fmap_axis_packer_sync_fifo.sv
// Show-ahead synchronous FIFO that buffers packed feature-map words.
// A push is allowed while full if a pop happens in the same cycle.
// Full and empty are registered so the AXIS side sees clean flop outputs.
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_wr_en;
  logic             w_rd_en;
  logic [AW:0]      w_count_nxt;

  // Qualify requests: pop only with data, push only with room or a freeing pop.
  always_comb begin
    w_rd_en = i_pop && !r_empty;
    w_wr_en = i_push && (!r_full || w_rd_en);
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_count_nxt = r_count;
    case ({w_wr_en, w_rd_en})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_CNT);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage array written on accepted pushes.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; empty/pointers guard it so it maps to RAM.
    if (w_wr_en) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Show-ahead read: the head entry is always presented.
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/fmap_axis_packer.sv
// Packs the CNN pooled-sample stream into AXI4-Stream words for DMA.
// Samples are sign-extended, tagged with TLAST at frame end, and buffered.
// The source has no backpressure, so losses are reported through sticky flags.
// Optional macro AXIS_TUSER_SOF_EN adds m_axis_tuser marking the first word of a frame.
module fmap_axis_packer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int TDATA_WIDTH  = DEF_TDATA_WIDTH,
  parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_in,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   end_in,
  input  logic                   clear_err,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
`ifdef AXIS_TUSER_SOF_EN
  output logic                   m_axis_tuser,
`endif
  output logic                   overflow,
  output logic                   short_frame,
  output logic                   frame_done
);

  localparam int                FCNT_W   = cnt_width(FRAME_PIXELS);
  localparam logic [FCNT_W-1:0] LAST_IDX = FCNT_W'(FRAME_PIXELS - 1);

`ifdef AXIS_TUSER_SOF_EN
  typedef struct packed {
    logic                   sof;
    logic                   last;
    logic [TDATA_WIDTH-1:0] data;
  } entry_t;
`else
  typedef struct packed {
    logic                   last;
    logic [TDATA_WIDTH-1:0] data;
  } entry_t;
`endif

  localparam int ENTRY_W = $bits(entry_t);

  pack_state_e       r_state;
  pack_state_e       w_state_nxt;
  logic [FCNT_W-1:0] r_cnt;
  logic [FCNT_W-1:0] w_pix_idx;
  logic              w_is_last;
  logic              w_sof;

  logic              r_overflow;
  logic              r_short_frame;
  logic              r_frame_done;

  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_short;
  logic              w_full;
  logic              w_empty;
  entry_t            w_wr_entry;
  entry_t            w_rd_entry;
  logic [ENTRY_W-1:0] w_rd_bits;

  // Frame-position state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: a sample opens a frame, a last sample closes it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (valid_in && !w_is_last) w_state_nxt = ST_FRAME;
      ST_FRAME: if (valid_in &&  w_is_last) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: pixel index within the frame, last-sample and start-of-frame tags.
  always_comb begin
    w_pix_idx = (r_state == ST_IDLE) ? '0 : r_cnt;
    w_is_last = end_in || (w_pix_idx == LAST_IDX);
    w_sof     = (r_state == ST_IDLE);
  end

  // Pixel counter advances on every sample, dropped or not, to keep frame alignment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_cnt <= '0;
    else if (valid_in) r_cnt <= w_is_last ? '0 : w_pix_idx + FCNT_W'(1);
  end

  // Handshake, push qualification and error detection.
  always_comb begin
    w_pop   = !w_empty && m_axis_tready;
    w_push  = valid_in && (!w_full || w_pop);
    w_drop  = valid_in && !w_push;
    w_short = valid_in && end_in && (w_pix_idx < LAST_IDX);
  end

  // Build the FIFO entry from the widened sample and its tags.
  always_comb begin
    w_wr_entry      = '0;
    w_wr_entry.data = TDATA_WIDTH'($signed(data_in));
    w_wr_entry.last = w_is_last;
`ifdef AXIS_TUSER_SOF_EN
    w_wr_entry.sof  = w_sof;
`endif
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wr_entry),
    .o_rdata (w_rd_bits),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_rd_entry = entry_t'(w_rd_bits);

  // Sticky error flags: a new error in the clearing cycle wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow    <= 1'b0;
      r_short_frame <= 1'b0;
    end else begin
      r_overflow    <= w_drop  || (r_overflow    && !clear_err);
      r_short_frame <= w_short || (r_short_frame && !clear_err);
    end
  end

  // Pulse one cycle after the TLAST word is accepted downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_frame_done <= 1'b0;
    else       r_frame_done <= w_pop && w_rd_entry.last;
  end

  // AXIS outputs are forced to zero when no word is presented.
  always_comb begin
    m_axis_tvalid = !w_empty;
    m_axis_tdata  = m_axis_tvalid ? w_rd_entry.data : '0;
    m_axis_tlast  = m_axis_tvalid && w_rd_entry.last;
  end

`ifdef AXIS_TUSER_SOF_EN
  assign m_axis_tuser = m_axis_tvalid && w_rd_entry.sof;
`endif

  assign overflow    = r_overflow;
  assign short_frame = r_short_frame;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_fmap_axis_packer.sv
// Directed bench for fmap_axis_packer with a scoreboard queue of expected words.
// Small frame (4 pixels) and small FIFO (4 entries) to reach every corner quickly.
module tb_fmap_axis_packer;

  localparam int DW = 20;
  localparam int TW = 32;
  localparam int FP = 4;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          end_in;
  logic          clear_err;
  logic [TW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          overflow;
  logic          short_frame;
  logic          frame_done;
`ifdef AXIS_TUSER_SOF_EN
  logic          tuser;
`endif

  always #5 clk = ~clk;

  fmap_axis_packer #(
    .DATA_WIDTH   (DW),
    .TDATA_WIDTH  (TW),
    .FRAME_PIXELS (FP),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .end_in        (end_in),
    .clear_err     (clear_err),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
`ifdef AXIS_TUSER_SOF_EN
    .m_axis_tuser  (tuser),
`endif
    .overflow      (overflow),
    .short_frame   (short_frame),
    .frame_done    (frame_done)
  );

  typedef struct {
    logic [TW-1:0] data;
    logic          last;
    logic          sof;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model of the input side.
  int   m_cnt   = 0;
  bit   m_idle  = 1'b1;
  bit   m_ov    = 1'b0;
  bit   m_short = 1'b0;
  bit   m_fd    = 1'b0;

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs, advance the model.
  task automatic cyc(input bit v, input int d, input bit e, input bit rdy, input bit clr);
    exp_t          x;
    logic [DW-1:0] ds;
    bit            hs;
    bit            full;
    bit            acc;
    bit            last;
    @(negedge clk);
    valid_in  = v;
    data_in   = DW'(d);
    end_in    = e;
    tready    = rdy;
    clear_err = clr;
    chk("tvalid", TW'(tvalid), TW'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("tdata", tdata, sb[0].data);
      chk("tlast", TW'(tlast), TW'(sb[0].last));
`ifdef AXIS_TUSER_SOF_EN
      chk("tuser", TW'(tuser), TW'(sb[0].sof));
`endif
    end
    chk("overflow",    TW'(overflow),    TW'(m_ov));
    chk("short_frame", TW'(short_frame), TW'(m_short));
    chk("frame_done",  TW'(frame_done),  TW'(m_fd));
    full = (sb.size() == FD);
    hs   = (sb.size() != 0) && rdy;
    m_fd = 1'b0;
    if (hs) begin
      m_fd = sb[0].last;
      void'(sb.pop_front());
    end
    acc     = v && (!full || hs);
    last    = e || (m_cnt == FP - 1);
    m_ov    = (v && !acc) || (m_ov && !clr);
    m_short = (v && e && (m_cnt < FP - 1)) || (m_short && !clr);
    if (v) begin
      if (acc) begin
        ds     = DW'(d);
        x.data = {{(TW-DW){ds[DW-1]}}, ds};
        x.last = last;
        x.sof  = m_idle;
        sb.push_back(x);
      end
      m_cnt  = last ? 0 : m_cnt + 1;
      m_idle = last;
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    valid_in  = 1'b0;
    data_in   = '0;
    end_in    = 1'b0;
    clear_err = 1'b0;
    tready    = 1'b0;
    #1;
    chk("rst_tvalid",      TW'(tvalid),      '0);
    chk("rst_tdata",       tdata,            '0);
    chk("rst_tlast",       TW'(tlast),       '0);
    chk("rst_overflow",    TW'(overflow),    '0);
    chk("rst_short_frame", TW'(short_frame), '0);
    chk("rst_frame_done",  TW'(frame_done),  '0);
    sb.delete();
    m_cnt   = 0;
    m_idle  = 1'b1;
    m_ov    = 1'b0;
    m_short = 1'b0;
    m_fd    = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    valid_in  = 1'b0;
    data_in   = '0;
    end_in    = 1'b0;
    clear_err = 1'b0;
    tready    = 1'b0;
    do_reset();

    // Full frame with end_in on the final sample, sign extension of -3.
    cyc(1'b1,  5, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, -3, 1'b0, 1'b1, 1'b0);
    cyc(1'b1,  7, 1'b0, 1'b1, 1'b0);
    cyc(1'b1,  9, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Short frame, then a following frame closed by the pixel count alone.
    cyc(1'b1, 11, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 12, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
    for (int i = 0; i < FP; i++) cyc(1'b1, 13 + i, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);
    // New short-frame error in the same cycle as a clear: the error wins.
    cyc(1'b1, 20, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 21, 1'b1, 1'b1, 1'b1);
    idle(2, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);

    // Overflow: six samples into a stalled four-entry FIFO, then drain.
    for (int i = 0; i < 6; i++) cyc(1'b1, 30 + i, 1'b0, 1'b0, 1'b0);
    idle(6, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b1);
    // Fill again, then push while full with a simultaneous pop: no drop.
    for (int i = 0; i < FD; i++) cyc(1'b1, 40 + i, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 44, 1'b0, 1'b1, 1'b0);
    idle(6, 1'b1);
    cyc(1'b1, 45, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Stall with tready toggling every cycle: head word must hold steady.
    for (int i = 0; i < FP; i++) cyc(1'b1, -50 - i, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) idle(1, i[0]);
    idle(2, 1'b1);

    // Reset in the middle of a frame, then a fresh four-sample frame.
    cyc(1'b1, 60, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 61, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < FP; i++) cyc(1'b1, 70 + i, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Two back-to-back frames; start-of-frame on words 1 and 5.
    for (int i = 0; i < 2 * FP; i++) cyc(1'b1, 80 + i, 1'b0, 1'b1, 1'b0);
    idle(4, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
